des_dec_iter: RTL and testbench
===============================

DES_DEC_ITER -- requirements
Module: des_dec_iter

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed by DES.
REQ-002 The block SHALL have these ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  C/K offered
- in_ready  output  1  block can accept
- C  input  [64:1]  ciphertext, bit 1 = MSB (DES numbering)
- K  input  [64:1]  key incl. parity bits 8,16,...,64
- out_valid  output  1  DEC_OUT holds a result
- out_ready  input  1  consumer takes result
- DEC_OUT  output  [64:1]  recovered plaintext
- busy  output  1  rounds in progress
- key_err  output  1  key parity fault; see Configuration
REQ-003 The block SHALL use one clock; reset SHALL be synchronous and active-high.

Function
REQ-004 The block SHALL be a round-serial DES decryptor, one Feistel round per clock, with a three-state FSM: IDLE, ROUND, DONE.
REQ-005 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE; busy SHALL be 1 only in ROUND.
REQ-006 Accept on an edge with in_valid=1 in IDLE: load L||R = IP(C) and C28||D28 = PC1(K), clear the round counter to 0, go to ROUND.
REQ-007 In ROUND, each edge SHALL apply one round: L'=R, R'=L xor f(R, PC2(C28||D28)), with subkeys K16 down to K1.
REQ-008 The key schedule SHALL be decryption order: right-rotate C28/D28 by 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 before rounds 1..16 (no shift before round 1).
REQ-009 f SHALL be E-expansion, xor with the subkey, S1..S8 lookup (row = outer bits, column = inner 4 bits), then P permutation, all per FIPS 46-3.
REQ-010 On the 16th round edge the block SHALL register DEC_OUT = FP(R16||L16) (halves swapped) and enter DONE; out_valid rises 16 edges after the accept edge.
REQ-011 In DONE, DEC_OUT and key_err SHALL hold stable until out_ready=1; on that edge go to IDLE and drop out_valid.
REQ-012 in_valid in ROUND or DONE SHALL be ignored; C/K changes after acceptance SHALL NOT affect the block in flight.
REQ-013 in_ready is low in DONE, so a new accept is possible no earlier than the edge after the output handshake; minimum period 18 cycles/block.
REQ-014 DEC_OUT SHALL keep its last value in IDLE and change only on the REQ-010 edge.
REQ-015 Output SHALL be bit-exact with the team's combinational DES_dec for the same C and K.

Reset
REQ-016 rst=1 on an edge SHALL force IDLE, round counter 0, out_valid=0, busy=0, DEC_OUT=0, key_err=0; in_ready=1 from the next cycle.
REQ-017 Reset in ROUND or DONE SHALL abort the block with no output; rst has priority over every handshake.

Configuration
REQ-018 Macro DES_DEC_KEY_PARITY_EN defined: on accept, register key_err = 1 if any key byte K[8i-7:8i] has even parity; decryption still proceeds, and key_err is valid with out_valid.
REQ-019 DES_DEC_KEY_PARITY_EN undefined: key_err SHALL be tied to 0, parity bits SHALL be ignored, and no parity logic SHALL be built.

Verification
REQ-020 The bench SHALL cover these scenarios:
- C=85E813540F0AB405, K=133457799BBCDFF1, out_ready=1 -> out_valid 16 edges after accept; DEC_OUT=0123456789ABCDEF; key_err=0.
- C=0000000000000000, K=0E329232EA6D0D73 -> DEC_OUT=8787878787878787; busy high for exactly 16 cycles.
- out_ready=0 for 10 cycles in DONE, C/K/in_valid toggled -> DEC_OUT and out_valid stable; in_ready=0; one handshake then IDLE.
- rst pulsed at round 7, then a new block accepted -> no out_valid for the aborted block; next result correct; DEC_OUT=0 right after reset.
- K=0000000000000000 -> key_err=1 with the macro, 0 without; DEC_OUT matches DES_dec in both builds.
- 100 random {C,K}: encrypt with DES_enc, decrypt with this block, back-to-back with out_ready=1 -> DEC_OUT equals the original plaintext; accepts spaced exactly 18 cycles apart.

Source files
------------

// File: rtl/des_dec_iter.sv
// des_dec_iter: round-serial DES decryptor with one Feistel round per clock and subkeys K16..K1.
// Define DES_DEC_KEY_PARITY_EN to flag keys whose bytes are not odd parity on key_err.
module des_dec_iter (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [64:1] C,
    input  logic [64:1] K,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [64:1] DEC_OUT,
    output logic        busy,
    output logic        key_err
);
    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
    localparam int E_T [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,  8,  9, 10, 11,
        12, 13, 12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21,
        22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
    localparam int P_T [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10, 23, 19, 12,  4,
        26,  8, 16,  7, 27, 20, 13,  2, 41, 52, 31, 37, 47, 55, 30, 40,
        51, 45, 33, 48, 44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    // S1..S8, each 64 entries laid out row-major (row*16 + column).
    localparam int SBOX [512] = '{
        14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,  0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
         4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0, 15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13,
        15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,  3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
         0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15, 13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9,
        10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8, 13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
        13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,  1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12,
         7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15, 13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
        10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,  3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14,
         2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9, 14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
         4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14, 11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3,
        12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11, 10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
         9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,  4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13,
         4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1, 13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
         1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,  6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12,
        13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,  1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
         7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,  2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11};

    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    // Internal vectors are ascending [1:N] so DES bit n is simply index n.
    function automatic logic [1:64] f_ip(input logic [1:64] x);
        logic [1:64] y;
        for (int i = 1; i <= 64; i++) y[i] = x[IP_T[i-1]];
        return y;
    endfunction

    function automatic logic [1:64] f_fp(input logic [1:64] x);
        logic [1:64] y;
        for (int i = 1; i <= 64; i++) y[IP_T[i-1]] = x[i];
        return y;
    endfunction

    function automatic logic [1:56] f_pc1(input logic [1:64] x);
        logic [1:56] y;
        for (int i = 1; i <= 56; i++) y[i] = x[PC1_T[i-1]];
        return y;
    endfunction

    function automatic logic [1:48] f_pc2(input logic [1:56] x);
        logic [1:48] y;
        for (int i = 1; i <= 48; i++) y[i] = x[PC2_T[i-1]];
        return y;
    endfunction

    function automatic logic [1:28] f_rotr(input logic [1:28] h, input logic [1:0] n);
        case (n)
            2'd1:    return {h[28], h[1:27]};
            2'd2:    return {h[27:28], h[1:26]};
            default: return h;
        endcase
    endfunction

    function automatic logic [1:32] f_feistel(input logic [1:32] r, input logic [1:48] k);
        logic [1:48] x;
        logic [1:32] s;
        logic [1:32] y;
        logic [5:0]  b;
        for (int i = 1; i <= 48; i++) x[i] = r[E_T[i-1]] ^ k[i];
        for (int n = 0; n < 8; n++) begin
            b = x[6*n+1 +: 6];
            s[4*n+1 +: 4] = 4'(SBOX[64*n + int'({b[5], b[0], b[4:1]})]);
        end
        for (int i = 1; i <= 32; i++) y[i] = s[P_T[i-1]];
        return y;
    endfunction

    state_t      r_state, w_state_next;
    logic [1:32] r_l, r_r;
    logic [1:56] r_cd;
    logic [3:0]  r_cnt;
    logic [64:1] r_dout;
    logic [1:64] w_c, w_k, w_ip, w_fp;
    logic [1:56] w_pc1, w_cd_rot;
    logic [1:48] w_subkey;
    logic [1:32] w_r_next;
    logic [1:0]  w_rot;

    assign w_c      = C;
    assign w_k      = K;
    assign w_ip     = f_ip(w_c);
    assign w_pc1    = f_pc1(w_k);
    // Decryption walks the schedule backwards: round 1 uses the unrotated PC1 halves (K16).
    assign w_rot    = (r_cnt == 4'd0) ? 2'd0 :
                      (r_cnt == 4'd1 || r_cnt == 4'd8 || r_cnt == 4'd15) ? 2'd1 : 2'd2;
    assign w_cd_rot = {f_rotr(r_cd[1:28], w_rot), f_rotr(r_cd[29:56], w_rot)};
    assign w_subkey = f_pc2(w_cd_rot);
    assign w_r_next = r_l ^ f_feistel(r_r, w_subkey);
    assign w_fp     = f_fp({w_r_next, r_r});
    assign DEC_OUT  = r_dout;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    // NOTE: every signal driven here gets a default first so no path can leave one unassigned (no latch).
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_next = ROUND;
            end
            ROUND: begin
                busy = 1'b1;
                if (r_cnt == 4'd15) w_state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // NOTE: the L/R/CD working registers are left out of reset; they are always loaded on accept before use.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= 4'd0;
            r_dout <= '0;
        end else begin
            case (r_state)
                IDLE: if (in_valid) begin
                    r_l   <= w_ip[1:32];
                    r_r   <= w_ip[33:64];
                    r_cd  <= w_pc1;
                    r_cnt <= 4'd0;
                end
                ROUND: begin
                    r_l   <= r_r;
                    r_r   <= w_r_next;
                    r_cd  <= w_cd_rot;
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == 4'd15) r_dout <= w_fp;
                end
                default: ;
            endcase
        end
    end

`ifdef DES_DEC_KEY_PARITY_EN
    logic r_key_err;
    logic w_parity_err;

    always_comb begin
        w_parity_err = 1'b0;
        for (int i = 0; i < 8; i++) if (~^K[8*i+1 +: 8]) w_parity_err = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)                               r_key_err <= 1'b0;
        else if (r_state == IDLE && in_valid)  r_key_err <= w_parity_err;
    end

    assign key_err = r_key_err;
`else
    assign key_err = 1'b0;
`endif

endmodule

// File: tb/tb_des_dec_iter.sv
// Self-checking bench for des_dec_iter: directed known-answer cases plus random blocks
// checked against a whole-block DES model that precomputes all sixteen subkeys.
module tb_des_dec_iter;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready, busy, key_err;
    logic [64:1] C, K, DEC_OUT;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    int acc_cyc = 0;

    des_dec_iter dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .C(C), .K(K),
        .out_valid(out_valid), .out_ready(out_ready), .DEC_OUT(DEC_OUT), .busy(busy), .key_err(key_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    localparam int T_IP = 0, T_FP = 1, T_E = 2, T_P = 3, T_PC1 = 4, T_PC2 = 5;
    int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4, 62,54,46,38,30,22,14,6,
                      64,56,48,40,32,24,16,8, 57,49,41,33,25,17,9,1, 59,51,43,35,27,19,11,3,
                      61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
    int FP_T [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31, 38,6,46,14,54,22,62,30,
                      37,5,45,13,53,21,61,29, 36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                      34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
    int E_T [48]  = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                      16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
    int P_T [32]  = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10, 2,8,24,14,32,27,3,9,
                      19,13,30,6,22,11,4,25};
    int PC1_T [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27,
                       19,11,3,60,52,44,36, 63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                       14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
    int PC2_T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                       41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
    int SB [8][64] = '{
        '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
          4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
        '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
          0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
        '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
          13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
        '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
          10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
        '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
          4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
        '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
          9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
        '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
          1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
        '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
          7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

    function automatic int tbl(input int id, input int i);
        case (id)
            T_IP:    return IP_T[i];
            T_FP:    return FP_T[i];
            T_E:     return E_T[i];
            T_P:     return P_T[i];
            T_PC1:   return PC1_T[i];
            default: return PC2_T[i];
        endcase
    endfunction

    // Values are right-aligned integers; DES bit n of an in_w-bit value sits at x[in_w - n].
    function automatic logic [63:0] perm(input logic [63:0] x, input int in_w, input int id, input int out_w);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < out_w; i++) y = {y[62:0], x[in_w - tbl(id, i)]};
        return y;
    endfunction

    function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] e;
        logic [31:0] s;
        logic [5:0]  six;
        int          row, col;
        e = 48'(perm(64'(r), 32, T_E, 48)) ^ k;
        s = '0;
        for (int j = 0; j < 8; j++) begin
            six = e[47-6*j -: 6];
            row = 2 * int'(six[5]) + int'(six[0]);
            col = int'(six[4:1]);
            s = {s[27:0], 4'(SB[j][16*row + col])};
        end
        return 32'(perm(64'(s), 32, T_P, 32));
    endfunction

    function automatic logic [63:0] des(input logic [63:0] blk, input logic [63:0] key, input bit decrypt);
        logic [47:0] ks [16];
        logic [55:0] cd;
        logic [27:0] c, d;
        logic [63:0] ip;
        logic [31:0] l, r, t;
        int          sh;
        cd = 56'(perm(key, 64, T_PC1, 56));
        c = cd[55:28];
        d = cd[27:0];
        for (int i = 0; i < 16; i++) begin
            sh = (i == 0 || i == 1 || i == 8 || i == 15) ? 1 : 2;
            c = (c << sh) | (c >> (28 - sh));
            d = (d << sh) | (d >> (28 - sh));
            ks[i] = 48'(perm({8'h00, c, d}, 56, T_PC2, 48));
        end
        ip = perm(blk, 64, T_IP, 64);
        l = ip[63:32];
        r = ip[31:0];
        for (int i = 0; i < 16; i++) begin
            t = r;
            r = l ^ feistel(r, decrypt ? ks[15-i] : ks[i]);
            l = t;
        end
        return perm({r, l}, 64, T_FP, 64);
    endfunction

    function automatic logic exp_kerr(input logic [63:0] k);
        logic bad;
        bad = 1'b0;
`ifdef DES_DEC_KEY_PARITY_EN
        for (int i = 0; i < 8; i++) if ($countones(k[8*i +: 8]) % 2 == 0) bad = 1'b1;
`else
        bad = bad & k[0];
`endif
        return bad;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [63:0] c, input logic [63:0] k);
        int n;
        n = 0;
        while (!in_ready && n < 40) begin tick; n++; end
        check("in_ready_before_accept", 64'(in_ready), 64'd1);
        C = c; K = k; in_valid = 1'b1;
        tick;
        acc_cyc = cyc;
        in_valid = 1'b0;
        C = {$urandom, $urandom};
        K = {$urandom, $urandom};
    endtask

    task automatic wait_done(output int lat, output int nbusy);
        lat = 0;
        nbusy = 0;
        while (!out_valid && lat < 40) begin
            if (busy) nbusy++;
            tick;
            lat++;
        end
    endtask

    logic [63:0] pt, key, ct, hold;
    int          lat, nb, prev_acc, seen;

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; C = '0; K = '0;
        tick; tick;
        rst = 1'b0;
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy",      64'(busy),      64'd0);
        check("rst_dec_out",   DEC_OUT,        64'd0);
        check("rst_key_err",   64'(key_err),   64'd0);

        // FIPS worked example.
        out_ready = 1'b1;
        start(64'h85E813540F0AB405, 64'h133457799BBCDFF1);
        wait_done(lat, nb);
        check("kat1_latency", 64'(lat),       64'd16);
        check("kat1_dec_out", DEC_OUT,        64'h0123456789ABCDEF);
        check("kat1_key_err", 64'(key_err),   64'd0);
        tick;
        check("kat1_hs_out_valid", 64'(out_valid), 64'd0);
        check("kat1_hs_in_ready",  64'(in_ready),  64'd1);
        check("idle_dec_out_hold", DEC_OUT,        64'h0123456789ABCDEF);

        start(64'h0000000000000000, 64'h0E329232EA6D0D73);
        wait_done(lat, nb);
        check("kat2_busy_cycles", 64'(nb), 64'd16);
        check("kat2_dec_out",     DEC_OUT, 64'h8787878787878787);
        tick;

        // Consumer stalls in DONE while inputs churn.
        out_ready = 1'b0;
        pt = {$urandom, $urandom}; key = {$urandom, $urandom};
        ct = des(pt, key, 1'b0);
        start(ct, key);
        wait_done(lat, nb);
        check("stall_dec_out", DEC_OUT, pt);
        hold = DEC_OUT;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'($urandom);
            C = {$urandom, $urandom};
            K = {$urandom, $urandom};
            tick;
            check("stall_hold_dec_out",   DEC_OUT,         hold);
            check("stall_hold_out_valid", 64'(out_valid), 64'd1);
            check("stall_in_ready_low",   64'(in_ready),  64'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick;
        check("stall_release_out_valid", 64'(out_valid), 64'd0);
        check("stall_release_in_ready",  64'(in_ready),  64'd1);
        check("stall_release_busy",      64'(busy),      64'd0);

        // Abort during round 7.
        start(64'h85E813540F0AB405, 64'h133457799BBCDFF1);
        for (int i = 0; i < 6; i++) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("abort_dec_out",   DEC_OUT,         64'd0);
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_busy",      64'(busy),      64'd0);
        check("abort_in_ready",  64'(in_ready),  64'd1);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) seen++;
            tick;
        end
        check("abort_no_out_valid", 64'(seen), 64'd0);
        start(64'h0000000000000000, 64'h0E329232EA6D0D73);
        wait_done(lat, nb);
        check("after_abort_dec_out", DEC_OUT, 64'h8787878787878787);
        tick;

        // All-zero key: every byte has even parity.
        ct = {$urandom, $urandom};
        start(ct, 64'h0);
        wait_done(lat, nb);
        check("zero_key_dec_out", DEC_OUT,       des(ct, 64'h0, 1'b1));
        check("zero_key_key_err", 64'(key_err), 64'(exp_kerr(64'h0)));
        tick;

        // Back-to-back random round trips.
        prev_acc = 0;
        for (int i = 0; i < 100; i++) begin
            pt  = {$urandom, $urandom};
            key = {$urandom, $urandom};
            ct  = des(pt, key, 1'b0);
            start(ct, key);
            if (i > 0) check("rand_accept_spacing", 64'(acc_cyc - prev_acc), 64'd18);
            prev_acc = acc_cyc;
            wait_done(lat, nb);
            check("rand_dec_out", DEC_OUT,       pt);
            check("rand_key_err", 64'(key_err), 64'(exp_kerr(key)));
            tick;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
